// File: rtl/priority_encoder4x2.sv
// rtl/priority_encoder4x2.sv - registered 4-to-2 priority encoder with request latching and valid/ack handshake
module priority_encoder4x2 #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] in,
  input  logic         ack,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [N-1:0] pend
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] dout_q, dout_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] clr_mask;
  logic [W-1:0] top_idx;

  // Highest-index pending bit; later iterations override earlier ones.
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pend_q[i]) begin
        top_idx = W'(i);
      end
    end
  end

  // A fresh request on the bit being retired re-arms it: set wins over clear.
  always_comb begin
    clr_mask = '0;
    if (state_q == GRANT && ack) begin
      clr_mask[dout_q] = 1'b1;
    end
    pend_d = (pend_q & ~clr_mask) | (in & {N{en}});
  end

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        dout_d = '0;
        if (pend_q != '0) begin
          state_d = GRANT;
          dout_d  = top_idx;
        end
      end
      GRANT: begin
        if (ack) begin
          state_d = IDLE;
          dout_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        dout_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dout_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      pend_q  <= pend_d;
    end
  end

  assign dout  = dout_q;
  assign valid = (state_q == GRANT);
  assign pend  = pend_q;

endmodule

// File: tb/tb_priority_encoder4x2.sv
// tb/tb_priority_encoder4x2.sv - randomized and directed bench for priority_encoder4x2
module tb_priority_encoder4x2;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk;
  logic         rst;
  logic         en;
  logic [N-1:0] in;
  logic         ack;
  logic [W-1:0] dout;
  logic         valid;
  logic [N-1:0] pend;

  int total;
  int bad;

  // Reference: set of pending request numbers and the granted request (-1 = none).
  bit m_pending [N];
  int m_grant;

  priority_encoder4x2 #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .in    (in),
    .ack   (ack),
    .dout  (dout),
    .valid (valid),
    .pend  (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] model_pend();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = m_pending[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_pending[i] = 1'b0;
    m_grant = -1;
  endtask

  task automatic model_edge(input logic e, input logic [N-1:0] r, input logic a);
    int  retire;
    int  top;
    bit  nxt [N];
    retire = (m_grant >= 0 && a) ? m_grant : -1;
    top = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (m_pending[i] && top < 0) top = i;
    end
    for (int i = 0; i < N; i++) begin
      nxt[i] = (e && r[i]) || (m_pending[i] && i != retire);
    end
    if (m_grant < 0) m_grant = top;
    else if (a) m_grant = -1;
    for (int i = 0; i < N; i++) m_pending[i] = nxt[i];
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 32'(valid), 32'(m_grant >= 0));
    chk({tag, ".dout"}, 32'(dout), (m_grant >= 0) ? 32'(m_grant) : 32'd0);
    chk({tag, ".pend"}, 32'(pend), 32'(model_pend()));
  endtask

  task automatic step(input logic e, input logic [N-1:0] r, input logic a);
    @(negedge clk);
    en  = e;
    in  = r;
    ack = a;
    @(posedge clk);
    if (rst) model_clear();
    else model_edge(e, r, a);
    #1;
    check_model("step");
  endtask

  task automatic reset_mid(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    ack = 1'b1;
    #1;
    model_clear();
    chk({tag, ".valid"}, 32'(valid), 32'd0);
    chk({tag, ".dout"}, 32'(dout), 32'd0);
    chk({tag, ".pend"}, 32'(pend), 32'd0);
    @(posedge clk);
    #1;
    check_model({tag, ".held"});
    @(negedge clk);
    rst = 1'b0;
    ack = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    en    = 1'b1;
    in    = 4'b1111;
    ack   = 1'b0;
    model_clear();
    #1;
    chk("reset.valid", 32'(valid), 32'd0);
    chk("reset.dout", 32'(dout), 32'd0);
    chk("reset.pend", 32'(pend), 32'd0);
    @(posedge clk);
    #1;
    chk("reset.hold_pend", 32'(pend), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in  = '0;

    // Single request
    step(1'b1, 4'b0100, 1'b0);
    chk("single.pend", 32'(pend), 32'b0100);
    chk("single.valid0", 32'(valid), 32'd0);
    step(1'b1, 4'b0000, 1'b0);
    chk("single.valid", 32'(valid), 32'd1);
    chk("single.dout", 32'(dout), 32'd2);
    step(1'b1, 4'b0000, 1'b1);
    chk("single.retire_valid", 32'(valid), 32'd0);
    chk("single.retire_pend", 32'(pend), 32'd0);

    // Priority ordering with ack held high
    step(1'b1, 4'b1011, 1'b1);
    step(1'b1, 4'b0000, 1'b1);
    chk("prio.first", 32'(dout), 32'd3);
    step(1'b1, 4'b0000, 1'b1);
    chk("prio.gap", 32'(valid), 32'd0);
    step(1'b1, 4'b0000, 1'b1);
    chk("prio.second", 32'(dout), 32'd1);
    step(1'b1, 4'b0000, 1'b1);
    step(1'b1, 4'b0000, 1'b1);
    chk("prio.third_valid", 32'(valid), 32'd1);
    chk("prio.third", 32'(dout), 32'd0);
    step(1'b1, 4'b0000, 1'b1);
    chk("prio.done", 32'(pend), 32'd0);

    // No preemption
    step(1'b1, 4'b0001, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b1000, 1'b0);
      chk("nopre.hold", 32'(dout), 32'd0);
    end
    step(1'b1, 4'b0000, 1'b1);
    step(1'b1, 4'b0000, 1'b0);
    chk("nopre.next", 32'(dout), 32'd3);
    step(1'b1, 4'b0000, 1'b1);

    // Enable gating
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'b1111, 1'b0);
      chk("gate.pend", 32'(pend), 32'd0);
    end
    step(1'b1, 4'b1111, 1'b0);
    chk("gate.capture", 32'(pend), 32'b1111);
    step(1'b0, 4'b0000, 1'b0);
    chk("gate.grant", 32'(dout), 32'd3);
    for (int i = 0; i < 8; i++) step(1'b0, 4'b0000, 1'b1);
    chk("gate.drained", 32'(pend), 32'd0);

    // Set wins over clear
    step(1'b1, 4'b0010, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    chk("setwin.grant", 32'(dout), 32'd1);
    step(1'b1, 4'b0010, 1'b1);
    chk("setwin.valid", 32'(valid), 32'd0);
    chk("setwin.pend", 32'(pend), 32'b0010);
    step(1'b1, 4'b0000, 1'b0);
    chk("setwin.regrant", 32'(dout), 32'd1);
    step(1'b1, 4'b0000, 1'b1);

    // Asynchronous reset mid-grant
    step(1'b1, 4'b1100, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    chk("arst.pre_pend", 32'(pend), 32'b1100);
    reset_mid("arst");

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      logic          e;
      logic [N-1:0]  r;
      logic          a;
      e = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      a = ($urandom_range(0, 1) == 1);
      step(e, r, a);
      if ($urandom_range(0, 99) == 0) reset_mid("rand_arst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
